// File: rtl/ring_buffer_wr_arbiter_pkg.sv
// Shared types for the ring buffer write-port arbiter.
// FSM state encoding and grant index width helper.
package ring_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // clog2 with a floor of 1 so a 2-producer build still has a 1-bit id
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_buffer_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // scan from the farthest offset down so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ring_buffer_wr_arbiter.sv
// Burst-based round-robin arbiter sharing one ring buffer write port.
// Grantee holds the port until last beat, burst cap or idle timeout.
module ring_buffer_wr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    buf_full,
  output logic                    buf_wr_en,
  output logic [WIDTH-1:0]        buf_data_in,
  output logic                    grant_vld,
  output logic [id_w(NREQ)-1:0]   grant_id
);

  localparam int IW = id_w(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] gid_nxt, next_ptr;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [CW-1:0] idle_cnt, idle_nxt;
  logic          found;
  logic [IW-1:0] pick;
  logic          vld, beat, rel;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  assign grant_vld   = (state == ST_GRANT);
  assign vld         = req_valid[grant_id];
  assign beat        = grant_vld && vld && !buf_full;
  assign buf_wr_en   = beat;
  assign buf_data_in = req_data[grant_id*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = !buf_full;
  end

  assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // a full-buffer stall keeps valid high, so it never feeds the idle count
  assign rel = (beat && (req_last[grant_id] ||
                         beat_cnt == BW'(MAX_BURST - 1))) ||
               (!vld && idle_cnt == CW'(IDLE_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    idle_nxt  = idle_cnt;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_GRANT;
          gid_nxt   = pick;
        end
      end
      ST_GRANT: begin
        if (beat) beat_nxt = beat_cnt + 1'b1;
        idle_nxt = vld ? '0 : idle_cnt + 1'b1;
        if (rel) begin
          state_nxt = ST_IDLE;
          rr_nxt    = next_ptr;
          beat_nxt  = '0;
          idle_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= gid_nxt;
      beat_cnt <= beat_nxt;
      idle_cnt <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_ring_buffer_wr_arbiter.sv
// Directed bench for ring_buffer_wr_arbiter: vector table plus
// hand-written burst cap, backpressure, timeout and reset sequences.
module tb_ring_buffer_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        buf_full = 1'b0;
  logic        buf_wr_en;
  logic [7:0]  buf_data_in;
  logic        grant_vld;
  logic [1:0]  grant_id;

  ring_buffer_wr_arbiter #(
    .WIDTH        (8),
    .NREQ         (4),
    .MAX_BURST    (8),
    .IDLE_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .buf_full    (buf_full),
    .buf_wr_en   (buf_wr_en),
    .buf_data_in (buf_data_in),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       gv;
    logic [3:0] rdy;
    logic       wr;
    logic [7:0] data;
    logic [1:0] gid;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  int total = 0;
  int bad = 0;

  // producer model
  int         rem[4];
  int         seq[4];
  logic [3:0] last_en;
  logic [7:0] base[4];
  logic [3:0] acc;
  logic       full_q;
  logic [7:0] wlog[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] v, input logic [3:0] l,
    input logic f, input logic g, input logic [3:0] rd,
    input logic w, input logic [7:0] d, input logic [1:0] id);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.full = f;
    t.gv = g; t.rdy = rd; t.wr = w; t.data = d; t.gid = id;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = last_en[i] && rem[i] == 1;
      req_data[i*8 +: 8] = base[i] + 8'(seq[i]);
    end
    buf_full = full_q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin
        seq[i]++;
        rem[i]--;
      end
    acc = '0;
    apply();
    @(negedge clk);
    acc = req_ready & req_valid;
    if (buf_wr_en) wlog.push_back(buf_data_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    last_en = '0;
    full_q = 1'b0;
    acc = '0;
    wlog.delete();
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_log(input int n, input int lim, input string nm);
    int k;
    k = 0;
    while (wlog.size() < n && k < lim) begin
      tick();
      k++;
    end
    chk(nm, wlog.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e3[12];
    base[0] = 8'h00; base[1] = 8'h40;
    base[2] = 8'h80; base[3] = 8'hC0;

    // reset and round robin, one row per cycle
    tbl[0]  = mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 0);
    tbl[2]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h1, 1, 8'hA0, 0);
    tbl[3]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 0);
    tbl[4]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h2, 1, 8'hA1, 1);
    tbl[5]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 1);
    tbl[6]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h4, 1, 8'hA2, 2);
    tbl[7]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 2);
    tbl[8]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h8, 1, 8'hA3, 3);
    tbl[9]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 8'h00, 3);
    tbl[10] = mk(0, 4'hF, 4'hF, 0, 1, 4'h1, 1, 8'hA0, 0);
    tbl[11] = mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 8'h00, 0);
    tbl[12] = mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 8'h00, 0);
    tbl[13] = mk(0, 4'h2, 4'hF, 1, 0, 4'h0, 0, 8'h00, 0);
    tbl[14] = mk(0, 4'h2, 4'hF, 1, 1, 4'h0, 0, 8'h00, 1);
    tbl[15] = mk(0, 4'h2, 4'hF, 0, 1, 4'h2, 1, 8'hA1, 1);
    tbl[16] = mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 0, 8'h00, 1);

    for (int r = 0; r < NV; r++) begin
      @(posedge clk);
      #1;
      rst       = tbl[r].rst;
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      buf_full  = tbl[r].full;
      req_data  = 32'hA3A2A1A0;
      @(negedge clk);
      chk($sformatf("row%0d grant_vld", r), grant_vld, tbl[r].gv);
      chk($sformatf("row%0d req_ready", r), req_ready, tbl[r].rdy);
      chk($sformatf("row%0d buf_wr_en", r), buf_wr_en, tbl[r].wr);
      chk($sformatf("row%0d grant_id", r), grant_id, tbl[r].gid);
      if (tbl[r].wr)
        chk($sformatf("row%0d data", r), buf_data_in, tbl[r].data);
    end

    // burst cap: req0 streams, req1 slips in after 8 beats
    do_reset();
    rem[0] = 20; last_en[0] = 1'b0;
    rem[1] = 1;  last_en[1] = 1'b1;
    e3 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h40, 8'h08, 8'h09, 8'h0A};
    wait_log(12, 40, "cap count");
    for (int i = 0; i < 12; i++)
      if (i < wlog.size())
        chk($sformatf("cap beat%0d", i), wlog[i], e3[i]);

    // full backpressure mid-burst
    do_reset();
    rem[0] = 6; last_en[0] = 1'b1;
    wait_log(2, 10, "bp pre");
    full_q = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d ready", c), req_ready, 4'h0);
      chk($sformatf("bp%0d wr_en", c), buf_wr_en, 1'b0);
      chk($sformatf("bp%0d grant", c), grant_vld, 1'b1);
    end
    full_q = 1'b0;
    wait_log(6, 20, "bp post");
    repeat (3) tick();
    chk("bp total", wlog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < wlog.size())
        chk($sformatf("bp beat%0d", i), wlog[i], 8'(i));
    chk("bp released", grant_vld, 1'b0);

    // idle timeout hands the port to req2
    do_reset();
    rem[0] = 2; last_en[0] = 1'b0;
    rem[2] = 1; last_en[2] = 1'b1;
    wait_log(2, 10, "to pre");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to idle%0d grant", c), grant_vld, 1'b1);
    end
    tick();
    chk("to bubble", grant_vld, 1'b0);
    tick();
    chk("to grant", grant_vld, 1'b1);
    chk("to grant_id", grant_id, 2'd2);
    chk("to data", buf_data_in, 8'h80);

    // mid-burst reset restarts round robin at 0
    do_reset();
    rem[1] = 1; last_en[1] = 1'b1;
    wait_log(1, 10, "mr pre");
    repeat (2) tick();
    rem[0] = 6; last_en[0] = 1'b1;
    wait_log(4, 10, "mr burst");
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("mr grant", grant_vld, 1'b0);
    chk("mr ready", req_ready, 4'h0);
    chk("mr wr_en", buf_wr_en, 1'b0);
    acc = '0;
    rem[3] = 1; last_en[3] = 1'b1;
    apply();
    @(posedge clk);
    @(negedge clk);
    chk("mr held", grant_vld, 1'b0);
    rst = 1'b0;
    wlog.delete();
    tick();
    chk("mr regrant", grant_vld, 1'b1);
    chk("mr grant_id", grant_id, 2'd0);
    chk("mr data", buf_data_in, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
